// File: rtl/regfile_2r1w_sb.sv
// regfile_2r1w_sb: 2**ADDR_W x DATA_W register file with two read ports, one
// write port, optional write-through bypass, optional registered reads and a
// per-register busy scoreboard. After reset a clear sequencer zeroes one entry
// per cycle; the array itself carries no reset.
//
// Ports:
//   i_clk                   clock, all state changes on posedge
//   i_reset                 synchronous active-high reset, restarts the clear sequence
//   i_write/i_writenum/i_data_in   write port (accepted only when o_ready)
//   i_readnum_a/o_data_out_a       read port A
//   i_readnum_b/o_data_out_b       read port B
//   i_reserve/i_reservenum         mark a register as pending a write (only when o_ready)
//   o_busy_a/o_busy_b       busy bit of the register addressed by each read port
//   o_ready                 1 once the clear sequence has finished
module regfile_2r1w_sb #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned ADDR_W   = 3,
  parameter bit          REG_READ = 1'b0,
  parameter bit          BYPASS   = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_write,
  input  logic [ADDR_W-1:0] i_writenum,
  input  logic [DATA_W-1:0] i_data_in,
  input  logic [ADDR_W-1:0] i_readnum_a,
  output logic [DATA_W-1:0] o_data_out_a,
  input  logic [ADDR_W-1:0] i_readnum_b,
  output logic [DATA_W-1:0] o_data_out_b,
  input  logic              i_reserve,
  input  logic [ADDR_W-1:0] i_reservenum,
  output logic              o_busy_a,
  output logic              o_busy_b,
  output logic              o_ready
);

  localparam int unsigned N = 2 ** ADDR_W;
  // Counter is one bit wider than the address so the terminal count is exact.
  localparam logic [ADDR_W:0] LastIdx = (ADDR_W + 1)'(N - 1);

  typedef enum logic [0:0] {StClear, StRun} state_e;

  state_e              r_state, w_state_next;
  logic [ADDR_W:0]     r_cnt, w_cnt_next;
  logic [DATA_W-1:0]   r_mem [N];
  logic [N-1:0]        r_busy, w_busy_next;

  logic                w_ready;
  logic                w_run_wr;
  logic                w_run_res;
  logic                w_fwd_a, w_fwd_b;
  logic [DATA_W-1:0]   w_rd_a, w_rd_b;

  assign w_ready   = (r_state == StRun);
  assign w_run_wr  = w_ready & i_write;
  assign w_run_res = w_ready & i_reserve;
  assign o_ready   = w_ready;

  // Clear sequencer
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    unique case (r_state)
      StClear: begin
        w_cnt_next = r_cnt + 1'b1;
        if (r_cnt == LastIdx) w_state_next = StRun;
      end
      StRun:   w_state_next = StRun;
      default: w_state_next = StClear;
    endcase
    if (i_reset) begin
      w_state_next = StClear;
      w_cnt_next   = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    r_state <= w_state_next;
    r_cnt   <= w_cnt_next;
  end

  // Scoreboard: write clears, reserve sets; set is applied last so it wins.
  always_comb begin
    w_busy_next = r_busy;
    if (w_run_wr)  w_busy_next[i_writenum]   = 1'b0;
    if (w_run_res) w_busy_next[i_reservenum] = 1'b1;
    if (i_reset)   w_busy_next = '0;
  end

  always_ff @(posedge i_clk) begin
    r_busy <= w_busy_next;
  end

  // Array has no reset; the clear sequencer zeroes it instead.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      if (r_state == StClear) begin
        r_mem[r_cnt[ADDR_W-1:0]] <= '0;
      end else if (i_write) begin
        r_mem[i_writenum] <= i_data_in;
      end
    end
  end

  assign w_fwd_a = BYPASS && w_run_wr && (i_writenum == i_readnum_a);
  assign w_fwd_b = BYPASS && w_run_wr && (i_writenum == i_readnum_b);
  assign w_rd_a  = w_fwd_a ? i_data_in : r_mem[i_readnum_a];
  assign w_rd_b  = w_fwd_b ? i_data_in : r_mem[i_readnum_b];

  assign o_busy_a = r_busy[i_readnum_a];
  assign o_busy_b = r_busy[i_readnum_b];

  if (REG_READ) begin : g_reg_read
    logic [DATA_W-1:0] r_q_a, r_q_b;

    // Capture zero outside RUN so the first RUN cycle never shows a stale entry.
    always_ff @(posedge i_clk) begin
      if (i_reset || !w_ready) begin
        r_q_a <= '0;
        r_q_b <= '0;
      end else begin
        r_q_a <= w_rd_a;
        r_q_b <= w_rd_b;
      end
    end

    assign o_data_out_a = w_ready ? r_q_a : '0;
    assign o_data_out_b = w_ready ? r_q_b : '0;
  end else begin : g_comb_read
    assign o_data_out_a = w_ready ? w_rd_a : '0;
    assign o_data_out_b = w_ready ? w_rd_b : '0;
  end

endmodule

// File: tb/tb_regfile_2r1w_sb.sv
// Testbench for regfile_2r1w_sb. Two instances share all inputs: one with
// combinational reads and bypass, one with registered reads and no bypass.
// Every cycle both are compared against a reference model of the register
// file, its scoreboard and the clear timing.
module tb_regfile_2r1w_sb;

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 3;
  localparam int unsigned N  = 8;

  logic          clk = 1'b0;
  logic          reset, write, reserve;
  logic [AW-1:0] writenum, readnum_a, readnum_b, reservenum;
  logic [DW-1:0] data_in;

  logic [DW-1:0] c_out_a, c_out_b, r_out_a, r_out_b;
  logic          c_busy_a, c_busy_b, r_busy_a, r_busy_b, c_ready, r_ready;

  always #5 clk = ~clk;

  regfile_2r1w_sb #(.DATA_W(DW), .ADDR_W(AW), .REG_READ(1'b0), .BYPASS(1'b1)) dut_comb (
    .i_clk(clk), .i_reset(reset), .i_write(write), .i_writenum(writenum),
    .i_data_in(data_in), .i_readnum_a(readnum_a), .o_data_out_a(c_out_a),
    .i_readnum_b(readnum_b), .o_data_out_b(c_out_b), .i_reserve(reserve),
    .i_reservenum(reservenum), .o_busy_a(c_busy_a), .o_busy_b(c_busy_b), .o_ready(c_ready)
  );

  regfile_2r1w_sb #(.DATA_W(DW), .ADDR_W(AW), .REG_READ(1'b1), .BYPASS(1'b0)) dut_reg (
    .i_clk(clk), .i_reset(reset), .i_write(write), .i_writenum(writenum),
    .i_data_in(data_in), .i_readnum_a(readnum_a), .o_data_out_a(r_out_a),
    .i_readnum_b(readnum_b), .o_data_out_b(r_out_b), .i_reserve(reserve),
    .i_reservenum(reservenum), .o_busy_a(r_busy_a), .o_busy_b(r_busy_b), .o_ready(r_ready)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model
  logic [DW-1:0] m_mem [N];
  bit            m_busy [N];
  int            m_since = 0;     // non-reset cycles since the last reset
  bit            m_known = 1'b0;  // a reset has been applied
  logic [DW-1:0] m_q_a = '0, m_q_b = '0;  // registered-read instance's captured data

  function automatic bit m_ready();
    return m_since >= int'(N);
  endfunction

  // One clock cycle: drive, compare outputs mid-cycle, then advance model at the edge.
  task automatic cycle(input bit rst, input bit wr, input int wn, input int din,
                       input int ra, input int rb, input bit res, input int rn);
    logic [DW-1:0] e_a, e_b;
    reset = rst; write = wr; writenum = AW'(wn); data_in = DW'(din);
    readnum_a = AW'(ra); readnum_b = AW'(rb); reserve = res; reservenum = AW'(rn);
    #4;
    if (m_known) begin
      e_a = (wr && wn == ra) ? DW'(din) : m_mem[ra];
      e_b = (wr && wn == rb) ? DW'(din) : m_mem[rb];
      if (!m_ready()) begin e_a = '0; e_b = '0; end
      check("ready_comb", 32'(c_ready), 32'(m_ready()));
      check("ready_reg", 32'(r_ready), 32'(m_ready()));
      check("comb_out_a", 32'(c_out_a), 32'(e_a));
      check("comb_out_b", 32'(c_out_b), 32'(e_b));
      check("reg_out_a", 32'(r_out_a), m_ready() ? 32'(m_q_a) : 32'd0);
      check("reg_out_b", 32'(r_out_b), m_ready() ? 32'(m_q_b) : 32'd0);
      check("busy_a", 32'(c_busy_a), 32'(m_busy[ra]));
      check("busy_b", 32'(c_busy_b), 32'(m_busy[rb]));
      check("busy_a_reg", 32'(r_busy_a), 32'(m_busy[ra]));
      check("busy_b_reg", 32'(r_busy_b), 32'(m_busy[rb]));
    end
    @(posedge clk);
    if (rst) begin
      m_since = 0; m_known = 1'b1; m_q_a = '0; m_q_b = '0;
      for (int i = 0; i < int'(N); i++) m_busy[i] = 1'b0;
    end else if (!m_ready()) begin
      m_mem[m_since] = '0;
      m_since++;
      m_q_a = '0; m_q_b = '0;
    end else begin
      m_q_a = m_mem[ra];
      m_q_b = m_mem[rb];
      if (wr) begin m_mem[wn] = DW'(din); m_busy[wn] = 1'b0; end
      if (res) m_busy[rn] = 1'b1;
    end
    #1;
  endtask

  task automatic idle(input int ra, input int rb);
    cycle(1'b0, 1'b0, 0, 0, ra, rb, 1'b0, 0);
  endtask

  initial begin
    reset = 1'b1; write = 1'b0; reserve = 1'b0; writenum = '0; data_in = '0;
    readnum_a = '0; readnum_b = '0; reservenum = '0;
    for (int i = 0; i < int'(N); i++) begin m_mem[i] = '0; m_busy[i] = 1'b0; end
    @(posedge clk); #1;

    // T1: one reset cycle, ready low for exactly N cycles, then every entry reads 0
    cycle(1'b1, 1'b0, 0, 0, 0, 0, 1'b0, 0);
    check("t1_ready_after_reset", 32'(c_ready), 32'd0);
    for (int i = 0; i < int'(N); i++) begin
      check("t1_ready_low", 32'(c_ready), 32'd0);
      cycle(1'b0, 1'b1, i, 16'hBEEF, i, N - 1 - i, 1'b1, i);  // ignored while clearing
    end
    check("t1_ready_high", 32'(c_ready), 32'd1);
    check("t1_busy_clear", 32'(c_busy_a), 32'd0);
    for (int i = 0; i < int'(N); i++) idle(i, N - 1 - i);

    // T2: write R3 then read on both ports
    cycle(1'b0, 1'b1, 3, 16'hABCD, 0, 0, 1'b0, 0);
    idle(3, 3);
    check("t2_comb_a", 32'(c_out_a), 32'hABCD);
    check("t2_comb_b", 32'(c_out_b), 32'hABCD);
    check("t2_reg_a", 32'(r_out_a), 32'hABCD);
    check("t2_reg_b", 32'(r_out_b), 32'hABCD);

    // T3: same-cycle write to R5 while reading it
    readnum_a = 3'd5; write = 1'b1; writenum = 3'd5; data_in = 16'h1234; #1;
    check("t3_bypass", 32'(c_out_a), 32'h1234);
    cycle(1'b0, 1'b1, 5, 16'h1234, 5, 5, 1'b0, 0);
    check("t3_no_bypass_old", 32'(r_out_a), 32'h0000);  // captured pre-write value
    idle(5, 5);

    // T4: reserve, clear by write, reserve+write same cycle keeps busy
    cycle(1'b0, 1'b0, 0, 0, 2, 2, 1'b1, 2);
    check("t4_busy_set", 32'(c_busy_a), 32'd1);
    cycle(1'b0, 1'b1, 2, 16'h5A5A, 2, 2, 1'b0, 0);
    check("t4_busy_cleared", 32'(c_busy_a), 32'd0);
    cycle(1'b0, 1'b1, 2, 16'h0F0F, 2, 0, 1'b1, 2);
    check("t4_set_wins", 32'(c_busy_a), 32'd1);
    idle(2, 2);

    // T5: reset pulsed mid-clear, then a write to R0 during CLEAR is ignored
    cycle(1'b0, 1'b1, 0, 16'h7777, 0, 1, 1'b0, 0);
    cycle(1'b1, 1'b0, 0, 0, 0, 0, 1'b0, 0);
    for (int i = 0; i < 4; i++) idle(i, i);
    cycle(1'b1, 1'b0, 0, 0, 0, 0, 1'b0, 0);
    cycle(1'b0, 1'b1, 0, 16'hFFFF, 0, 0, 1'b1, 0);
    for (int i = 1; i < int'(N); i++) begin
      check("t5_ready_low", 32'(c_ready), 32'd0);
      idle(0, 1);
    end
    check("t5_ready_high", 32'(c_ready), 32'd1);
    readnum_a = 3'd0; write = 1'b0; #1;
    check("t5_r0_zero", 32'(c_out_a), 32'd0);
    check("t5_r0_not_busy", 32'(c_busy_a), 32'd0);

    // T6: random traffic
    for (int k = 0; k < 10000; k++) begin
      cycle(($urandom_range(0, 599) == 0), ($urandom_range(0, 1) == 1),
            int'($urandom_range(0, N - 1)), int'($urandom_range(0, 16'hFFFF)),
            int'($urandom_range(0, N - 1)), int'($urandom_range(0, N - 1)),
            ($urandom_range(0, 2) == 0), int'($urandom_range(0, N - 1)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
